// File: rtl/vga_timing_pkg.sv
// Raster timing constants for the 1280x1024@60 Hz (108 MHz) VGA mode.
// Shared by the sync generator and its axis counters.
package vga_timing_pkg;

   localparam int unsigned COORD_W = 11;
   localparam int unsigned CNT_LIM = 2 ** COORD_W;

   localparam int unsigned H_VIS  = 1280;
   localparam int unsigned H_FP   = 48;
   localparam int unsigned H_SYNC = 112;
   localparam int unsigned H_BP   = 248;
   localparam int unsigned H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;

   localparam int unsigned V_VIS  = 1024;
   localparam int unsigned V_FP   = 1;
   localparam int unsigned V_SYNC = 3;
   localparam int unsigned V_BP   = 38;
   localparam int unsigned V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;

   localparam int unsigned H_SYNC_START = H_VIS + H_FP;
   localparam int unsigned H_SYNC_END   = H_SYNC_START + H_SYNC;
   localparam int unsigned V_SYNC_START = V_VIS + V_FP;
   localparam int unsigned V_SYNC_END   = V_SYNC_START + V_SYNC;

   typedef logic [COORD_W-1:0] coord_t;

endpackage

// File: rtl/vga_axis_counter.sv
// Free-running modulo-MAX counter for one raster axis.
// wrap flags the increment that takes the count from MAX-1 back to 0.
module vga_axis_counter
#(
   parameter int unsigned MAX = 1688
)
(
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic                               inc,
   output logic [vga_timing_pkg::COORD_W-1:0] cnt,
   output logic                               wrap
);
   import vga_timing_pkg::*;

   localparam coord_t LAST = COORD_W'(MAX - 1);

   coord_t cnt_q;
   coord_t cnt_d;

   // next count: hold, step, or wrap to zero at the last position
   always_comb begin
      wrap  = inc && (cnt_q == LAST);
      cnt_d = cnt_q;
      if (inc) begin
         cnt_d = wrap ? '0 : cnt_q + 1'b1;
      end
   end

   // count register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt = cnt_q;

endmodule

// File: rtl/vga_sync_gen.sv
// VGA raster timing generator: coordinates, display enable, frame start
// and polarity-controlled syncs delayed to match the pixel stage.
module vga_sync_gen
#(
   parameter int unsigned H_VIS    = vga_timing_pkg::H_VIS,
   parameter int unsigned H_FP     = vga_timing_pkg::H_FP,
   parameter int unsigned H_SYNC   = vga_timing_pkg::H_SYNC,
   parameter int unsigned H_BP     = vga_timing_pkg::H_BP,
   parameter int unsigned V_VIS    = vga_timing_pkg::V_VIS,
   parameter int unsigned V_FP     = vga_timing_pkg::V_FP,
   parameter int unsigned V_SYNC   = vga_timing_pkg::V_SYNC,
   parameter int unsigned V_BP     = vga_timing_pkg::V_BP,
   parameter logic        HS_POL   = 1'b1,
   parameter logic        VS_POL   = 1'b1,
   parameter int unsigned SYNC_DLY = 1
)
(
   input  logic                               VGA_CLK,
   input  logic                               rst_n,
   output logic [vga_timing_pkg::COORD_W-1:0] x,
   output logic [vga_timing_pkg::COORD_W-1:0] y,
   output logic                               disp_en,
   output logic                               hsync,
   output logic                               vsync,
   output logic                               frame_start
);
   import vga_timing_pkg::*;

   localparam int unsigned H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
   localparam int unsigned V_TOT = V_VIS + V_FP + V_SYNC + V_BP;
   localparam int unsigned CW1   = COORD_W + 1;

   // one extra bit so a boundary of exactly 2048 does not alias to 0
   localparam logic [CW1-1:0] H_VIS_C = CW1'(H_VIS);
   localparam logic [CW1-1:0] V_VIS_C = CW1'(V_VIS);
   localparam logic [CW1-1:0] HS_BEG  = CW1'(H_VIS + H_FP);
   localparam logic [CW1-1:0] HS_FIN  = CW1'(H_VIS + H_FP + H_SYNC);
   localparam logic [CW1-1:0] VS_BEG  = CW1'(V_VIS + V_FP);
   localparam logic [CW1-1:0] VS_FIN  = CW1'(V_VIS + V_FP + V_SYNC);

   if (H_TOT > CNT_LIM) begin : g_h_chk
      $error("H_TOTAL exceeds 11-bit counter range");
   end
   if (V_TOT > CNT_LIM) begin : g_v_chk
      $error("V_TOTAL exceeds 11-bit counter range");
   end
   if (SYNC_DLY > 4) begin : g_d_chk
      $error("SYNC_DLY must be 0..4");
   end

   coord_t h_cnt;
   coord_t v_cnt;
   logic   h_wrap;
   logic   v_wrap_unused;

   vga_axis_counter #(.MAX(H_TOT)) u_h_cnt (
      .clk   (VGA_CLK),
      .rst_n (rst_n),
      .inc   (1'b1),
      .cnt   (h_cnt),
      .wrap  (h_wrap)
   );

   vga_axis_counter #(.MAX(V_TOT)) u_v_cnt (
      .clk   (VGA_CLK),
      .rst_n (rst_n),
      .inc   (h_wrap),
      .cnt   (v_cnt),
      .wrap  (v_wrap_unused)
   );

   coord_t            x_q, x_d;
   coord_t            y_q, y_d;
   logic              de_q, de_d;
   logic              fs_q, fs_d;
   logic [SYNC_DLY:0] hs_q, hs_d;
   logic [SYNC_DLY:0] vs_q, vs_d;
   logic [CW1-1:0]    h_ext;
   logic [CW1-1:0]    v_ext;
   logic              hs_act;
   logic              vs_act;

   // decode counters into next output values and shift the sync delay line
   always_comb begin
      h_ext  = {1'b0, h_cnt};
      v_ext  = {1'b0, v_cnt};
      de_d   = (h_ext < H_VIS_C) && (v_ext < V_VIS_C);
      x_d    = de_d ? h_cnt : '0;
      y_d    = de_d ? v_cnt : '0;
      fs_d   = (h_cnt == '0) && (v_cnt == '0);
      hs_act = (h_ext >= HS_BEG) && (h_ext < HS_FIN);
      vs_act = (v_ext >= VS_BEG) && (v_ext < VS_FIN);
      hs_d    = hs_q;
      vs_d    = vs_q;
      hs_d[0] = hs_act ? HS_POL : ~HS_POL;
      vs_d[0] = vs_act ? VS_POL : ~VS_POL;
      for (int i = 1; i <= int'(SYNC_DLY); i++) begin
         hs_d[i] = hs_q[i-1];
         vs_d[i] = vs_q[i-1];
      end
   end

   // output registers; the delay line resets to the inactive sync level
   always_ff @(posedge VGA_CLK or negedge rst_n) begin
      if (!rst_n) begin
         x_q  <= '0;
         y_q  <= '0;
         de_q <= 1'b0;
         fs_q <= 1'b0;
         hs_q <= {(SYNC_DLY + 1){~HS_POL}};
         vs_q <= {(SYNC_DLY + 1){~VS_POL}};
      end else begin
         x_q  <= x_d;
         y_q  <= y_d;
         de_q <= de_d;
         fs_q <= fs_d;
         hs_q <= hs_d;
         vs_q <= vs_d;
      end
   end

   assign x           = x_q;
   assign y           = y_q;
   assign disp_en     = de_q;
   assign frame_start = fs_q;
   assign hsync       = hs_q[SYNC_DLY];
   assign vsync       = vs_q[SYNC_DLY];

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: small-raster instances with sync delays 0 and 2
// plus the default 1280x1024 instance, checked against a raster model.
module tb_vga_sync_gen;

   typedef struct packed {
      logic [10:0] x;
      logic [10:0] y;
      logic        de;
      logic        hs;
      logic        vs;
      logic        fs;
   } out_t;

   typedef struct {
      int hv, hf, hs, hb;
      int vv, vf, vs, vb;
      int dly;
   } cfg_t;

   typedef struct {
      int   t;
      int   dut;
      out_t exp;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   logic [10:0] xa, ya, xb, yb, xc, yc;
   logic        dea, hsa, vsa, fsa;
   logic        deb, hsb, vsb, fsb;
   logic        dec, hsc, vsc, fsc;

   out_t act_a, act_b, act_c;
   assign act_a = {xa, ya, dea, hsa, vsa, fsa};
   assign act_b = {xb, yb, deb, hsb, vsb, fsb};
   assign act_c = {xc, yc, dec, hsc, vsc, fsc};

   always #5 clk = ~clk;

   vga_sync_gen #(
      .H_VIS(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
      .V_VIS(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
      .HS_POL(1'b1), .VS_POL(1'b1), .SYNC_DLY(0)
   ) dut_a (
      .VGA_CLK(clk), .rst_n(rst_n), .x(xa), .y(ya), .disp_en(dea),
      .hsync(hsa), .vsync(vsa), .frame_start(fsa)
   );

   vga_sync_gen #(
      .H_VIS(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
      .V_VIS(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
      .HS_POL(1'b1), .VS_POL(1'b1), .SYNC_DLY(2)
   ) dut_b (
      .VGA_CLK(clk), .rst_n(rst_n), .x(xb), .y(yb), .disp_en(deb),
      .hsync(hsb), .vsync(vsb), .frame_start(fsb)
   );

   vga_sync_gen dut_c (
      .VGA_CLK(clk), .rst_n(rst_n), .x(xc), .y(yc), .disp_en(dec),
      .hsync(hsc), .vsync(vsc), .frame_start(fsc)
   );

   localparam cfg_t CA = '{8, 2, 2, 2, 4, 1, 1, 1, 0};
   localparam cfg_t CB = '{8, 2, 2, 2, 4, 1, 1, 1, 2};
   localparam cfg_t CC = '{1280, 48, 112, 248, 1024, 1, 3, 38, 1};

   int   errors = 0;
   int   checks = 0;
   int   vi = 0;
   int   fs_cnt = 0;
   int   de_cnt_c = 0;
   vec_t tab[$];
   out_t q_a[$], q_b[$], q_c[$];

   // outputs after t clock edges since reset release (t=0: still reset)
   function automatic out_t model(input int t, input cfg_t c);
      int   ht, vt, p, h, v;
      out_t o;
      ht = c.hv + c.hf + c.hs + c.hb;
      vt = c.vv + c.vf + c.vs + c.vb;
      o  = '0;
      if (t >= 1) begin
         p = (t - 1) % (ht * vt);
         h = p % ht;
         v = p / ht;
         o.de = (h < c.hv) && (v < c.vv);
         if (o.de) begin
            o.x = 11'(h);
            o.y = 11'(v);
         end
         o.fs = (p == 0);
      end
      if (t - 1 - c.dly >= 0) begin
         p = (t - 1 - c.dly) % (ht * vt);
         h = p % ht;
         v = p / ht;
         o.hs = (h >= c.hv + c.hf) && (h < c.hv + c.hf + c.hs);
         o.vs = (v >= c.vv + c.vf) && (v < c.vv + c.vf + c.vs);
      end
      return o;
   endfunction

   task automatic chk(input string name, input int t, input out_t a,
                      input out_t e);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s t=%0d: got x=%0d y=%0d de=%b hs=%b vs=%b fs=%b, want x=%0d y=%0d de=%b hs=%b vs=%b fs=%b",
                  name, t, a.x, a.y, a.de, a.hs, a.vs, a.fs,
                  e.x, e.y, e.de, e.hs, e.vs, e.fs);
      end
   endtask

   task automatic add(input int t, input int d, input int x, input int y,
                      input logic de, input logic hs, input logic vs,
                      input logic fs);
      vec_t v;
      v.t   = t;
      v.dut = d;
      v.exp = {11'(x), 11'(y), de, hs, vs, fs};
      tab.push_back(v);
   endtask

   task automatic run_sb(input int n, input bit use_tab);
      out_t e;
      for (int t = 1; t <= n; t++) begin
         q_a.push_back(model(t, CA));
         q_b.push_back(model(t, CB));
         q_c.push_back(model(t, CC));
         @(posedge clk);
         #1;
         e = q_a.pop_front();
         chk("sb_a", t, act_a, e);
         e = q_b.pop_front();
         chk("sb_b", t, act_b, e);
         e = q_c.pop_front();
         chk("sb_c", t, act_c, e);
         if (fsa) fs_cnt++;
         if (dec) de_cnt_c++;
         while (use_tab && vi < tab.size() && tab[vi].t == t) begin
            if (tab[vi].dut == 0) chk("vec_a", t, act_a, tab[vi].exp);
            else chk("vec_b", t, act_b, tab[vi].exp);
            vi++;
         end
      end
   endtask

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      int  n;
      bit  found;
      // t, dut, x, y, de, hs, vs, fs  (sorted by t)
      add( 1, 0, 0, 0, 1, 0, 0, 1);
      add( 8, 0, 7, 0, 1, 0, 0, 0);
      add( 9, 0, 0, 0, 0, 0, 0, 0);
      add(11, 0, 0, 0, 0, 1, 0, 0);
      add(12, 0, 0, 0, 0, 1, 0, 0);
      add(13, 0, 0, 0, 0, 0, 0, 0);
      add(13, 1, 0, 0, 0, 1, 0, 0);
      add(15, 0, 0, 1, 1, 0, 0, 0);
      add(15, 1, 0, 1, 1, 0, 0, 0);
      add(46, 0, 3, 3, 1, 0, 0, 0);
      add(67, 0, 0, 0, 0, 1, 0, 0);
      add(71, 0, 0, 0, 0, 0, 1, 0);
      add(72, 1, 0, 0, 0, 0, 0, 0);
      add(73, 1, 0, 0, 0, 0, 1, 0);
      add(84, 0, 0, 0, 0, 0, 1, 0);
      add(85, 0, 0, 0, 0, 0, 0, 0);
      add(86, 1, 0, 0, 0, 0, 1, 0);
      add(87, 1, 0, 0, 0, 0, 0, 0);
      add(99, 0, 0, 0, 1, 0, 0, 1);

      repeat (3) @(posedge clk);
      #1;
      chk("reset_a", 0, act_a, '0);
      chk("reset_b", 0, act_b, '0);
      chk("reset_c", 0, act_c, '0);
      @(negedge clk);
      rst_n = 1'b1;

      n = 2 * 1688 + 20;
      run_sb(n, 1'b1);

      checks++;
      if (vi != tab.size()) begin
         errors++;
         $display("FAIL vec_cover: applied %0d of %0d vectors", vi, tab.size());
      end
      checks++;
      if (fs_cnt != (n - 1) / 98 + 1) begin
         errors++;
         $display("FAIL fs_count: got %0d want %0d", fs_cnt, (n - 1) / 98 + 1);
      end
      checks++;
      if (de_cnt_c != 2580) begin
         errors++;
         $display("FAIL de_count_c: got %0d want 2580", de_cnt_c);
      end

      found = 1'b0;
      for (int k = 0; k < 200 && !found; k++) begin
         @(posedge clk);
         #1;
         if (xa == 11'd5 && ya == 11'd2 && dea) found = 1'b1;
      end
      checks++;
      if (!found) begin
         errors++;
         $display("FAIL wait_x5y2: got no x=5,y=2 within 200 clk");
      end
      rst_n = 1'b0;
      #1;
      chk("midrst_a", 0, act_a, '0);
      chk("midrst_b", 0, act_b, '0);
      chk("midrst_c", 0, act_c, '0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      run_sb(120, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
